serial_receiver: RTL and testbench
==================================

# serial_receiver

Deserializer for the lab-5 one-bit message stream: receives `WORDS` words of `WORD_SIZE` bits, MSB first, one bit per clock, with no framing, starting a fixed number of cycles after reset. Assembled words are presented on a ready/valid output through a 2-entry buffer, tagged with their word index. The block sits at the far end of the serial link from the message transmitter and shares its clock and reset. Its output feeds the checker/display logic.

## Interface
- `WORD_SIZE`, default 23: bits per word.
- `WORDS`, default 40: words per message; reception stops after this many.
- `LEAD_CYCLES`, default 1: sampling edges after reset release discarded before bit 0 of word 0. The transmitter's output register makes 1 correct.
- `IDX_W`, default `$clog2(WORDS)`: width of the word index.
- `clock`: input, 1 bit, clock.
- `reset`: input, 1 bit, asynchronous, active-high.
- `serialIn`: input, 1 bit, serial data, sampled every rising edge.
- `word_data`: output, `WORD_SIZE` bits, head-of-buffer word. Bit `WORD_SIZE-1` is the first bit received.
- `word_index`: output, `IDX_W` bits, message position of the head word (0-based).
- `word_valid`: output, 1 bit, buffer non-empty.
- `word_ready`: input, 1 bit, consumer accepts the head word this cycle.
- `overflow`: output, 1 bit, sticky: a completed word was dropped because the buffer was full.
- `done`: output, 1 bit, all `WORDS` words have been assembled (accepted or dropped).

## Operation
- States:
  - LEAD: discards `LEAD_CYCLES` samples via a lead counter.
  - SHIFT: assembles words.
  - DONE: terminal until reset.
- Reset values:
  - State is LEAD. Shift register, bit counter, word counter, lead counter and buffer are cleared.
  - Outputs: `word_data` = 0, `word_index` = 0, `word_valid` = 0, `overflow` = 0, `done` = 0.
- LEAD→SHIFT once `LEAD_CYCLES` edges have elapsed. With `LEAD_CYCLES` = 0, reset enters SHIFT directly.
- SHIFT, on every edge:
  - Shift register becomes `{shreg[WORD_SIZE-2:0], serialIn}`.
  - Bit counter increments.
  - When the bit counter reaches `WORD_SIZE-1`, the complete word (including the bit sampled on that edge) is pushed with the current word counter as its index. The bit counter then wraps to 0 and the word counter increments.
- Push when the buffer is full and there is no pop on the same edge: the word is dropped, `overflow` sets, and the word counter still increments.
- Push and pop on the same edge with the buffer full: both occur, no drop.
- After the push of word `WORDS-1` the state moves to DONE and `done` is asserted. In DONE, `serialIn` is ignored and the buffer continues to drain normally.
- Pop occurs when `word_valid && word_ready`. `word_ready` while empty has no effect.
- `word_data`/`word_index` hold stable while `word_valid` is high and there is no pop.
- Reset mid-message: everything is cleared immediately (asynchronous) and reception restarts with LEAD.

## Timing
- Edge 1 is the first rising edge with `reset` low.
- With the default `LEAD_CYCLES`, edges 2..24 sample word 0 bits 22..0, and word k bit b is sampled on edge `2 + 23k + (22-b)`.
- Latency: a word is pushed on the edge sampling its bit 0. `word_valid` is high immediately after that edge, with no additional register stage.
- `done` rises after the edge that samples the last bit of word `WORDS-1`: edge `LEAD_CYCLES + WORDS*WORD_SIZE` (edge 921 by default).
- Throughput: at most one push per `WORD_SIZE` edges. Overflow therefore requires `word_ready` low for more than `2*WORD_SIZE-1` edges.

## Structure
- Shared package `serial_pkg` holds:
  - `WORD_SIZE`/`WORDS` default constants, shared with the transmitter.
  - The `rx_state_t` enum {LEAD, SHIFT, DONE}.
  - The `rx_word_t` struct {data, index}.
- Sub-module `word_fifo2`: 2-entry FIFO of `rx_word_t` with push/pop/full/empty. Push and pop are permitted together when full.
- Top level holds the FSM, counters and shift register.

## Test plan
- Transmitter→receiver loopback with the transmitter's ROM and `word_ready` tied 1:
  - All 40 words arrive with indices 0..39, bit-exact to the ROM.
  - `done` is high after edge 921 and `overflow` stays 0.
- Driven stream of word 0 = 23'h7FFFFF and word 1 = 23'h555555:
  - `word_valid` rises after edge 24 with data 23'h7FFFFF, index 0.
  - Second word rises after edge 47 with data 23'h555555, index 1.
- `word_ready` held 0:
  - Words 0 and 1 are buffered.
  - Word 2 is dropped at edge 70 and `overflow` sets.
  - Raising ready then yields indices 0, 1, 3.
- Buffer full, with `word_ready` pulsed on the same edge as the word-3 push:
  - No drop and `overflow` stays 0.
- Reset asserted at edge 30 (mid word 1), then released:
  - Outputs are 0 immediately.
  - The next word presented has index 0 and reflects bits sampled from the new edge 2.
- `LEAD_CYCLES` = 0 variant:
  - The bit on edge 1 becomes the MSB of word 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the lab-5 serial link: message geometry,
// receiver FSM states and the buffered word record.
package serial_pkg;

    localparam int WORD_SIZE = 23;
    localparam int WORDS     = 40;

    typedef enum logic [1:0] {
        LEAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0]      data;
        logic [$clog2(WORDS)-1:0]  index;
    } rx_word_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry FIFO for assembled words. entry0 is always the head, so the
// head output comes straight from a register.
module word_fifo2
    import serial_pkg::*;
#(
    parameter type T = rx_word_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    logic [1:0] count;
    T           entry0;
    T           entry1;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only taken if a pop frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = entry0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (do_pop) begin
            if (count == 2'd2) begin
                entry0 <= entry1;
                if (do_push) begin
                    entry1 <= push_data;
                end
            end else if (do_push) begin
                entry0 <= push_data;
            end
            if (!do_push) begin
                count <= count - 2'd1;
            end
        end else if (do_push) begin
            if (count == 2'd0) begin
                entry0 <= push_data;
            end else begin
                entry1 <= push_data;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Deserializer for the lab-5 message stream: MSB-first words, no framing,
// reception starting a fixed number of edges after reset.
module serial_receiver #(
    parameter int WORD_SIZE   = serial_pkg::WORD_SIZE,
    parameter int WORDS       = serial_pkg::WORDS,
    parameter int LEAD_CYCLES = 1,
    parameter int IDX_W       = $clog2(WORDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serialIn,
    output logic [WORD_SIZE-1:0] word_data,
    output logic [IDX_W-1:0]     word_index,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 overflow,
    output logic                 done
);

    import serial_pkg::*;

    localparam int BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam int LEAD_W = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_SIZE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS - 1);
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
    localparam rx_state_t RESET_STATE = (LEAD_CYCLES == 0) ? rx_state_t'(SHIFT) : rx_state_t'(LEAD);

    typedef struct packed {
        logic [WORD_SIZE-1:0] data;
        logic [IDX_W-1:0]     index;
    } word_t;

    rx_state_t            state;
    // Only the older WORD_SIZE-1 bits are stored; the newest bit is serialIn itself.
    logic [WORD_SIZE-2:0] shreg;
    logic [WORD_SIZE-1:0] next_word;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     word_cnt;
    logic [LEAD_W-1:0]    lead_cnt;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    word_t                push_word;
    word_t                head_word;

    assign next_word = {shreg, serialIn};
    assign push      = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign pop       = !empty && word_ready;
    assign push_word = '{data: next_word, index: word_cnt};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            lead_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                LEAD: begin
                    if (lead_cnt == LEAD_LAST) begin
                        state <= SHIFT;
                    end else begin
                        lead_cnt <= lead_cnt + LEAD_W'(1);
                    end
                end
                SHIFT: begin
                    shreg <= next_word[WORD_SIZE-2:0];
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (word_cnt == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            word_cnt <= word_cnt + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

    word_fifo2 #(
        .T(word_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head_word),
        .full      (full),
        .empty     (empty)
    );

    assign word_data  = head_word.data;
    assign word_index = head_word.index;
    assign word_valid = !empty;
    assign done       = (state == DONE);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: scoreboard of expected words checked
// on every handshake, plus reset, overflow and lead-cycle checks.
module tb_serial_receiver;

    localparam int WS = 23;
    localparam int IW = 6;

    typedef struct {
        logic [WS-1:0] data;
        logic [IW-1:0] index;
    } exp_word_t;

    logic          clock;
    logic          reset;
    logic          serialIn;
    logic          word_ready;
    logic [WS-1:0] word_data;
    logic [IW-1:0] word_index;
    logic          word_valid;
    logic          overflow;
    logic          done;

    logic [WS-1:0] word_data0;
    logic [IW-1:0] word_index0;
    logic          word_valid0;
    logic          overflow0;
    logic          done0;

    exp_word_t expQ[$];
    int        passCount;
    int        checkCount;
    int        edgeCount;
    int        wordNo;

    serial_receiver dut (
        .clock      (clock),
        .reset      (reset),
        .serialIn   (serialIn),
        .word_data  (word_data),
        .word_index (word_index),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow),
        .done       (done)
    );

    serial_receiver #(.LEAD_CYCLES(0)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .serialIn   (serialIn),
        .word_data  (word_data0),
        .word_index (word_index0),
        .word_valid (word_valid0),
        .word_ready (1'b0),
        .overflow   (overflow0),
        .done       (done0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // One sampling edge; inputs change 1 time unit after the previous edge.
    task automatic applyStimulus(input logic b);
        serialIn = b;
        @(posedge clock);
        #1;
        edgeCount = edgeCount + 1;
    endtask

    task automatic sendWord(input logic [WS-1:0] data, input bit expectPush, input bit pulseLast);
        exp_word_t e;
        for (int b = WS - 1; b >= 0; b--) begin
            if (b == 0 && pulseLast) word_ready = 1'b1;
            applyStimulus(data[b]);
        end
        if (pulseLast) word_ready = 1'b0;
        if (expectPush) begin
            e.data  = data;
            e.index = IW'(wordNo);
            expQ.push_back(e);
        end
        wordNo = wordNo + 1;
    endtask

    task automatic startMessage(input logic readyVal);
        reset      = 1'b1;
        serialIn   = 1'b0;
        word_ready = readyVal;
        @(posedge clock);
        #1;
        expQ.delete();
        wordNo    = 0;
        edgeCount = 0;
        reset     = 1'b0;
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected word.
    always @(negedge clock) begin
        if (!reset && word_valid && word_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pop", 64'(word_index), 64'hFFFF);
            end else begin
                exp_word_t e;
                e = expQ.pop_front();
                checkOutput("pop_data", 64'(word_data), 64'(e.data));
                checkOutput("pop_index", 64'(word_index), 64'(e.index));
            end
        end
    end

    initial begin
        logic [WS-1:0] w;
        logic [WS-1:0] w0;
        passCount  = 0;
        checkCount = 0;
        edgeCount  = 0;
        wordNo     = 0;
        reset      = 1'b1;
        serialIn   = 1'b1;
        word_ready = 1'b0;
        #3;
        checkOutput("rst_data", 64'(word_data), 64'h0);
        checkOutput("rst_index", 64'(word_index), 64'h0);
        checkOutput("rst_valid", 64'(word_valid), 64'h0);
        checkOutput("rst_overflow", 64'(overflow), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);

        // Full 40-word message with the consumer always ready.
        startMessage(1'b1);
        applyStimulus(1'b0);
        for (int i = 0; i < WS - 1; i++) applyStimulus(1'b1);
        checkOutput("lead0_valid", 64'(word_valid0), 64'h1);
        checkOutput("lead0_data", 64'(word_data0), 64'h3FFFFF);
        checkOutput("lead0_index", 64'(word_index0), 64'h0);
        checkOutput("w0_early_valid", 64'(word_valid), 64'h0);
        applyStimulus(1'b1);
        expQ.push_back('{data: 23'h7FFFFF, index: 6'd0});
        wordNo = 1;
        checkOutput("w0_valid", 64'(word_valid), 64'h1);
        checkOutput("w0_data", 64'(word_data), 64'h7FFFFF);
        checkOutput("w0_index", 64'(word_index), 64'h0);
        sendWord(23'h555555, 1'b1, 1'b0);
        checkOutput("w1_valid", 64'(word_valid), 64'h1);
        checkOutput("w1_data", 64'(word_data), 64'h555555);
        checkOutput("w1_index", 64'(word_index), 64'h1);
        for (int k = 2; k < 39; k++) begin
            w = WS'($urandom);
            sendWord(w, 1'b1, 1'b0);
        end
        checkOutput("done_early", 64'(done), 64'h0);
        sendWord(23'h2AAAAB, 1'b1, 1'b0);
        checkOutput("done_edge", 64'(edgeCount), 64'd921);
        checkOutput("done_set", 64'(done), 64'h1);
        checkOutput("msg_overflow", 64'(overflow), 64'h0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1);
        checkOutput("post_done_valid", 64'(word_valid), 64'h0);
        checkOutput("post_done_queue", 64'(expQ.size()), 64'h0);
        checkOutput("lead0_done", 64'(done0), 64'h1);
        checkOutput("lead0_overflow", 64'(overflow0), 64'h1);

        // Consumer stalled: word 2 dropped, then 0, 1, 3 delivered.
        startMessage(1'b0);
        applyStimulus(1'b0);
        w0 = 23'h1234AB;
        sendWord(w0, 1'b1, 1'b0);
        sendWord(23'h0F0F0F, 1'b1, 1'b0);
        checkOutput("ovf_before", 64'(overflow), 64'h0);
        sendWord(23'h7A5A5A, 1'b0, 1'b0);
        checkOutput("ovf_set", 64'(overflow), 64'h1);
        checkOutput("ovf_hold_data", 64'(word_data), 64'(w0));
        checkOutput("ovf_hold_index", 64'(word_index), 64'h0);
        word_ready = 1'b1;
        sendWord(23'h00C3C3, 1'b1, 1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("ovf_queue", 64'(expQ.size()), 64'h0);
        checkOutput("ovf_sticky", 64'(overflow), 64'h1);

        // Full buffer with a pop on the same edge as the next push: nothing lost.
        startMessage(1'b0);
        applyStimulus(1'b0);
        sendWord(23'h111111, 1'b1, 1'b0);
        sendWord(23'h222222, 1'b1, 1'b0);
        sendWord(23'h333333, 1'b1, 1'b1);
        checkOutput("pp_overflow", 64'(overflow), 64'h0);
        checkOutput("pp_index", 64'(word_index), 64'h1);
        word_ready = 1'b1;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("pp_queue", 64'(expQ.size()), 64'h0);
        checkOutput("pp_empty", 64'(word_valid), 64'h0);

        // Asynchronous reset in the middle of word 1.
        startMessage(1'b0);
        applyStimulus(1'b0);
        sendWord(23'h6B6B6B, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1);
        checkOutput("mid_pre_valid", 64'(word_valid), 64'h1);
        reset = 1'b1;
        #1;
        checkOutput("mid_valid", 64'(word_valid), 64'h0);
        checkOutput("mid_data", 64'(word_data), 64'h0);
        checkOutput("mid_done", 64'(done), 64'h0);
        startMessage(1'b1);
        applyStimulus(1'b1);
        sendWord(23'h13579B, 1'b1, 1'b0);
        checkOutput("restart_index", 64'(word_index), 64'h0);
        checkOutput("restart_data", 64'(word_data), 64'h13579B);
        applyStimulus(1'b0);
        checkOutput("restart_queue", 64'(expQ.size()), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
